usb_rx: RTL and testbench

//  Low-speed (1.5 Mb/s) USB receiver, counterpart of usb_tx on the same D+/D- pair.

---
 rtl/usb_rx.sv | 210 +++++++++++++++++++++
 tb/tb_usb_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx.sv
// Low-speed USB receiver: recovers bit timing from D+/D-, NRZI-decodes, removes stuffed bits,
// tracks SYNC/EOP and hands packet bytes to the protocol layer as one-cycle strobes.
`timescale 1ns/1ps

package usb_rx_pkg;
    typedef struct packed {
        logic p;
        logic n;
    } d_port_t;

    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_J   = 2'b01,
        LINE_K   = 2'b10,
        LINE_SE1 = 2'b11
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ABORT
    } state_t;
endpackage

module usb_rx
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  d_port_t    d,
    output logic [7:0] data,
    output logic       valid,
    output logic       active,
    output logic       eop,
    output logic       err
);
    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_MID  = PW'(CLKS_PER_BIT / 2);

    line_t         line1, line2, line3, last_jk;
    logic [PW-1:0] phase;
    logic          jk_edge, sample, line_jk, bit_val;

    state_t     state, state_d;
    line_t      prev_jk, prev_jk_d;
    logic [2:0] bit_cnt, bit_cnt_d, ones, ones_d;
    logic [7:0] shift, shift_d, data_d;
    logic       valid_d, active_d, eop_d, err_d;
    logic       misaligned, misaligned_d, se0_seen, se0_seen_d;

    // Edges are seen on line2 while line3 (one clk later) is what gets sampled, so phase 0
    // lines up with the first clk of the new level in line3.
    assign jk_edge = (line2 == LINE_J || line2 == LINE_K) && (line2 != last_jk);
    assign sample  = (phase == PHASE_MID);
    assign line_jk = (line3 == LINE_J || line3 == LINE_K);
    assign bit_val = (line3 == prev_jk);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            line1   <= LINE_J;
            line2   <= LINE_J;
            line3   <= LINE_J;
            last_jk <= LINE_J;
            phase   <= '0;
        end else begin
            line1 <= line_t'({d.p, d.n});
            line2 <= line1;
            line3 <= line2;
            if (line2 == LINE_J || line2 == LINE_K) last_jk <= line2;
            if (jk_edge || phase == PHASE_LAST) phase <= '0;
            else                                phase <= phase + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            prev_jk    <= LINE_J;
            bit_cnt    <= '0;
            ones       <= '0;
            shift      <= '0;
            misaligned <= 1'b0;
            se0_seen   <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            active     <= 1'b0;
            eop        <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            prev_jk    <= prev_jk_d;
            bit_cnt    <= bit_cnt_d;
            ones       <= ones_d;
            shift      <= shift_d;
            misaligned <= misaligned_d;
            se0_seen   <= se0_seen_d;
            data       <= data_d;
            valid      <= valid_d;
            active     <= active_d;
            eop        <= eop_d;
            err        <= err_d;
        end
    end

    // NOTE: every combinational output is given a default first, so no branch can infer a latch.
    always_comb begin
        state_d      = state;
        prev_jk_d    = prev_jk;
        bit_cnt_d    = bit_cnt;
        ones_d       = ones;
        shift_d      = shift;
        misaligned_d = misaligned;
        se0_seen_d   = se0_seen;
        data_d       = data;
        active_d     = active;
        valid_d      = 1'b0;
        eop_d        = 1'b0;
        err_d        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (jk_edge && line2 == LINE_K) begin
                    state_d   = ST_SYNC;
                    bit_cnt_d = '0;
                    ones_d    = '0;
                    prev_jk_d = LINE_J;
                end
            end
            ST_SYNC: begin
                if (sample) begin
                    if (!line_jk) begin
                        state_d = ST_IDLE;
                    end else begin
                        prev_jk_d = line3;
                        // The trailing 1 of SYNC counts toward the stuffing run.
                        ones_d = bit_val ? ones + 3'd1 : 3'd0;
                        if (bit_cnt == 3'd7) begin
                            if (bit_val) begin
                                state_d   = ST_DATA;
                                active_d  = 1'b1;
                                bit_cnt_d = '0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else if (bit_val) begin
                            state_d = ST_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt + 3'd1;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    if (!line_jk) begin
                        state_d      = ST_EOP;
                        misaligned_d = (bit_cnt != 3'd0);
                    end else begin
                        prev_jk_d = line3;
                        if (ones == 3'd6) begin
                            if (bit_val) begin
                                state_d    = ST_ABORT;
                                err_d      = 1'b1;
                                active_d   = 1'b0;
                                se0_seen_d = 1'b0;
                            end else begin
                                ones_d = '0;
                            end
                        end else begin
                            ones_d    = bit_val ? ones + 3'd1 : 3'd0;
                            shift_d   = {bit_val, shift[7:1]};
                            bit_cnt_d = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                data_d  = shift_d;
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_EOP: begin
                if (sample) begin
                    if (line3 == LINE_J) begin
                        eop_d    = 1'b1;
                        err_d    = misaligned;
                        active_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else if (line3 == LINE_K) begin
                        err_d    = 1'b1;
                        active_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_ABORT: begin
                if (sample) begin
                    if (!line_jk)                         se0_seen_d = 1'b1;
                    else if (se0_seen && line3 == LINE_J) state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_usb_rx.sv
// Bench for usb_rx: a bit-stuffing NRZI line model drives packets, a scoreboard queue holds the
// expected bytes and a negedge monitor pops and compares them as valid strobes appear.
`timescale 1ns/1ps

module tb_usb_rx;
    import usb_rx_pkg::*;

    localparam d_port_t LJ   = '{p: 1'b0, n: 1'b1};
    localparam d_port_t LK   = '{p: 1'b1, n: 1'b0};
    localparam d_port_t LSE0 = '{p: 1'b0, n: 1'b0};

    typedef struct packed {
        int              nbytes;
        logic [3:0][7:0] b;
        int              tail_bits;
        logic [7:0]      tail;
        int              bit_clks;
        int              exp_valid;
        int              exp_eop;
        int              exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    d_port_t    d;
    logic [7:0] data;
    logic       valid, active, eop, err;

    usb_rx #(.CLKS_PER_BIT(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .d      (d),
        .data   (data),
        .valid  (valid),
        .active (active),
        .eop    (eop),
        .err    (err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    int         n_valid = 0, n_eop = 0, n_err = 0;
    logic       valid_q = 1'b0, eop_q = 1'b0, err_q = 1'b0;

    d_port_t lvl = LJ;
    int      ones = 0;
    int      bit_clks = 16;
    vec_t    vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            check("valid_has_expected_byte", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("data", data, exp_q.pop_front());
            check("valid_not_with_eop", eop, 0);
            check("valid_one_cycle", valid_q, 0);
        end
        if (eop) begin
            n_eop++;
            check("eop_one_cycle", eop_q, 0);
        end
        if (err) begin
            n_err++;
            check("err_one_cycle", err_q, 0);
        end
        valid_q <= valid;
        eop_q   <= eop;
        err_q   <= err;
    end

    task automatic hold(input d_port_t s, input int clks);
        d = s;
        repeat (clks) @(posedge clk);
    endtask

    task automatic tx_raw(input logic b);
        if (!b) lvl = (lvl == LJ) ? LK : LJ;
        hold(lvl, bit_clks);
    endtask

    task automatic tx_bit(input logic b);
        tx_raw(b);
        if (b) begin
            ones++;
            if (ones == 6) begin
                tx_raw(1'b0);
                ones = 0;
            end
        end else begin
            ones = 0;
        end
    endtask

    task automatic tx_sync();
        lvl  = LJ;
        ones = 0;
        for (int i = 0; i < 7; i++) tx_bit(1'b0);
        tx_bit(1'b1);
    endtask

    task automatic tx_byte(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) tx_bit(b[i]);
    endtask

    task automatic tx_eop();
        hold(LSE0, 2 * bit_clks);
        lvl = LJ;
        hold(LJ, bit_clks);
    endtask

    task automatic idle(input int nbits);
        hold(LJ, nbits * bit_clks);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int v0, e0, r0;
        v0 = n_valid; e0 = n_eop; r0 = n_err;
        bit_clks = v.bit_clks;
        tx_sync();
        #1 check({tag, "_active_after_sync"}, active, 1);
        for (int i = 0; i < v.nbytes; i++) begin
            exp_q.push_back(v.b[i]);
            tx_byte(v.b[i], 8);
        end
        tx_byte(v.tail, v.tail_bits);
        tx_eop();
        idle(4);
        check({tag, "_valid_count"}, n_valid - v0, v.exp_valid);
        check({tag, "_eop_count"}, n_eop - e0, v.exp_eop);
        check({tag, "_err_count"}, n_err - r0, v.exp_err);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_active_idle"}, active, 0);
    endtask

    task automatic run_random(input int nbytes, input int clks);
        int e0, r0;
        logic [7:0] b;
        e0 = n_eop; r0 = n_err;
        bit_clks = clks;
        tx_sync();
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            tx_byte(b, 8);
        end
        tx_eop();
        idle(3);
        check("rand_eop_count", n_eop - e0, 1);
        check("rand_err_count", n_err - r0, 0);
        check("rand_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int   v0, e0, r0;
        vec_t rec;

        vecs[0] = '{nbytes: 2, b: 32'h0000_A53C, tail_bits: 0, tail: 8'h00, bit_clks: 16,
                    exp_valid: 2, exp_eop: 1, exp_err: 0};
        vecs[1] = '{nbytes: 2, b: 32'h0000_7EFF, tail_bits: 0, tail: 8'h00, bit_clks: 16,
                    exp_valid: 2, exp_eop: 1, exp_err: 0};
        vecs[2] = '{nbytes: 1, b: 32'h0000_00C3, tail_bits: 4, tail: 8'h05, bit_clks: 16,
                    exp_valid: 1, exp_eop: 1, exp_err: 1};
        vecs[3] = '{nbytes: 3, b: 32'h0055_FF00, tail_bits: 0, tail: 8'h00, bit_clks: 15,
                    exp_valid: 3, exp_eop: 1, exp_err: 0};
        vecs[4] = '{nbytes: 4, b: 32'hFFFF_FFFF, tail_bits: 0, tail: 8'h00, bit_clks: 17,
                    exp_valid: 4, exp_eop: 1, exp_err: 0};
        vecs[5] = '{nbytes: 0, b: 32'h0000_0000, tail_bits: 0, tail: 8'h00, bit_clks: 16,
                    exp_valid: 0, exp_eop: 1, exp_err: 0};
        vecs[6] = '{nbytes: 2, b: 32'h0000_4281, tail_bits: 7, tail: 8'h7F, bit_clks: 15,
                    exp_valid: 2, exp_eop: 1, exp_err: 1};
        vecs[7] = '{nbytes: 1, b: 32'h0000_00FF, tail_bits: 0, tail: 8'h00, bit_clks: 15,
                    exp_valid: 1, exp_eop: 1, exp_err: 0};

        // Reset state, then a long idle J with nothing reported.
        reset = 1'b1;
        d     = LJ;
        repeat (4) @(posedge clk);
        #1;
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_active", active, 0);
        check("rst_eop", eop, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        idle(200);
        check("idle_valid_count", n_valid, 0);
        check("idle_eop_count", n_eop, 0);
        check("idle_err_count", n_err, 0);
        check("idle_active", active, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Seven unstuffed 1s after SYNC, garbage while aborted, then SE0+J.
        v0 = n_valid; e0 = n_eop; r0 = n_err;
        bit_clks = 16;
        tx_sync();
        for (int i = 0; i < 7; i++) tx_raw(1'b1);
        idle(0);
        #1;
        check("stuff_err_count", n_err - r0, 1);
        check("stuff_active", active, 0);
        for (int i = 0; i < 10; i++) tx_raw(1'b0);
        tx_eop();
        idle(4);
        check("abort_valid_count", n_valid - v0, 0);
        check("abort_eop_count", n_eop - e0, 0);
        check("abort_err_count", n_err - r0, 1);
        rec = '{nbytes: 1, b: 32'h0000_0012, tail_bits: 0, tail: 8'h00, bit_clks: 16,
                exp_valid: 1, exp_eop: 1, exp_err: 0};
        run_vec(rec, "recover");

        // Reset in the middle of the second byte.
        v0 = n_valid; e0 = n_eop; r0 = n_err;
        tx_sync();
        exp_q.push_back(8'h5A);
        tx_byte(8'h5A, 8);
        tx_byte(8'h0F, 4);
        #1 check("midrst_active_before", active, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_active", active, 0);
        check("midrst_valid", valid, 0);
        check("midrst_eop", eop, 0);
        check("midrst_err", err, 0);
        check("midrst_data", data, 0);
        d = LJ;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        idle(10);
        check("midrst_valid_count", n_valid - v0, 1);
        check("midrst_eop_count", n_eop - e0, 0);
        check("midrst_err_count", n_err - r0, 0);
        check("midrst_queue_empty", exp_q.size(), 0);

        // Bit-time skew, then back-to-back loopback traffic.
        for (int i = 0; i < 4; i++) run_random(8, (i % 2 == 0) ? 15 : 17);
        v0 = n_valid; e0 = n_eop;
        for (int i = 0; i < 30; i++) run_random(8, 16);
        check("loop_valid_count", n_valid - v0, 240);
        check("loop_eop_count", n_eop - e0, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
